// File: rtl/fft_pingpong_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pingpong_sched                                           |
// | Description : Ping-pong scheduler for loader, FFT core and unloader sharing |
// |               two working BRAM banks with per-bank ownership tracking.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_pingpong_sched #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sched_en,
  input  logic                 frame_avail,
  output logic                 load_go,
  output logic                 load_bank,
  input  logic                 load_busy,
  output logic                 fft_go,
  output logic                 fft_bank,
  input  logic                 fft_busy,
  output logic                 unload_go,
  output logic                 unload_bank,
  input  logic                 unload_busy,
  output logic                 sched_idle,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 sched_err
);

  localparam logic [2:0] c_FREE      = 3'd0;
  localparam logic [2:0] c_LOADING   = 3'd1;
  localparam logic [2:0] c_LOADED    = 3'd2;
  localparam logic [2:0] c_FFT       = 3'd3;
  localparam logic [2:0] c_DONE      = 3'd4;
  localparam logic [2:0] c_UNLOADING = 3'd5;

  localparam int              c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TMO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_GO   = 2'd1,
    ENG_ARM  = 2'd2,
    ENG_RUN  = 2'd3
  } eng_state_t;

  // Engine index: 0 = loader, 1 = FFT core, 2 = unloader
  eng_state_t           r_eng     [3];
  logic [c_TO_W-1:0]    r_tmo     [3];
  logic [2:0]           r_bank_st [2];
  logic [2:0]           r_ptr;
  logic [2:0]           r_sel;
  logic [2:0]           r_go;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic                 r_err;

  logic [2:0] w_busy;
  logic [2:0] w_start;

  function automatic logic [2:0] f_pre(input int e);
    case (e)
      0:       return c_FREE;
      1:       return c_LOADED;
      default: return c_DONE;
    endcase
  endfunction

  function automatic logic [2:0] f_active(input int e);
    case (e)
      0:       return c_LOADING;
      1:       return c_FFT;
      default: return c_UNLOADING;
    endcase
  endfunction

  function automatic logic [2:0] f_next(input int e);
    case (e)
      0:       return c_LOADED;
      1:       return c_DONE;
      default: return c_FREE;
    endcase
  endfunction

  assign w_busy  = {unload_busy, fft_busy, load_busy};
  assign w_start = {sched_en && (r_bank_st[r_ptr[2]] == c_DONE),
                    sched_en && (r_bank_st[r_ptr[1]] == c_LOADED),
                    sched_en && frame_avail && (r_bank_st[r_ptr[0]] == c_FREE)};

  // Engines only ever claim banks in mutually exclusive states, so their
  // same-cycle writes to r_bank_st always land on different banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < 3; e++) begin
        r_eng[e] <= ENG_IDLE;
        r_tmo[e] <= '0;
      end
      r_bank_st[0]  <= c_FREE;
      r_bank_st[1]  <= c_FREE;
      r_ptr         <= '0;
      r_sel         <= '0;
      r_go          <= '0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_go <= '0;
      for (int e = 0; e < 3; e++) begin
        case (r_eng[e])
          ENG_IDLE: begin
            if (w_start[e]) begin
              r_eng[e]              <= ENG_GO;
              r_go[e]               <= 1'b1;
              r_sel[e]              <= r_ptr[e];
              r_bank_st[r_ptr[e]]   <= f_active(e);
            end
          end
          ENG_GO: begin
            r_eng[e] <= ENG_ARM;
            r_tmo[e] <= '0;
          end
          ENG_ARM: begin
            if (w_busy[e]) begin
              r_eng[e] <= ENG_RUN;
            end else if (r_tmo[e] == c_TMO_LAST) begin
              r_err                <= 1'b1;
              r_bank_st[r_sel[e]]  <= f_pre(e);
              r_eng[e]             <= ENG_IDLE;
            end else begin
              r_tmo[e] <= r_tmo[e] + 1'b1;
            end
          end
          ENG_RUN: begin
            if (!w_busy[e]) begin
              r_bank_st[r_sel[e]] <= f_next(e);
              r_ptr[e]            <= ~r_ptr[e];
              r_eng[e]            <= ENG_IDLE;
              if (e == 2) r_frame_count <= r_frame_count + 1'b1;
            end
          end
          default: r_eng[e] <= ENG_IDLE;
        endcase
      end
    end
  end

  assign load_go     = r_go[0];
  assign fft_go      = r_go[1];
  assign unload_go   = r_go[2];
  assign load_bank   = r_sel[0];
  assign fft_bank    = r_sel[1];
  assign unload_bank = r_sel[2];
  assign frame_count = r_frame_count;
  assign sched_err   = r_err;
  assign sched_idle  = (r_bank_st[0] == c_FREE) && (r_bank_st[1] == c_FREE) &&
                       (r_eng[0] == ENG_IDLE) && (r_eng[1] == ENG_IDLE) &&
                       (r_eng[2] == ENG_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_pingpong_sched                                        |
// | Description : Directed + randomized bench with frame-level engine models.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_pingpong_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sched_en = 1'b0;
  logic        frame_avail = 1'b0;
  logic [2:0]  busy_v = '0;
  logic        load_go, fft_go, unload_go;
  logic        load_bank, fft_bank, unload_bank;
  logic        sched_idle, sched_err;
  logic [15:0] frame_count;
  logic [2:0]  go_v, bank_v;

  fft_pingpong_sched #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .sched_en(sched_en), .frame_avail(frame_avail),
    .load_go(load_go), .load_bank(load_bank), .load_busy(busy_v[0]),
    .fft_go(fft_go), .fft_bank(fft_bank), .fft_busy(busy_v[1]),
    .unload_go(unload_go), .unload_bank(unload_bank), .unload_busy(busy_v[2]),
    .sched_idle(sched_idle), .frame_count(frame_count), .sched_err(sched_err)
  );

  assign go_v   = {unload_go, fft_go, load_go};
  assign bank_v = {unload_bank, fft_bank, load_bank};

  always #5 clk = ~clk;

  int   total = 0, bad = 0, cyc = 0;
  int   ph[3], cnt[3], len[3], completed[3], ngo[3], lo[3], hi[3];
  logic act[3], bank_of[3], hang[3];
  logic bp_arm = 1'b0, bp_wait = 1'b0;
  int   bp_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine models: a frame is owned by its engine from go until busy drops.
  // Frame k of each engine must use bank k%2, and a frame can only be
  // loaded/transformed/unloaded once the upstream stage has finished it.
  initial begin
    for (int k = 0; k < 3; k++) begin
      ph[k] = 0; cnt[k] = 0; len[k] = 0; completed[k] = 0; ngo[k] = 0;
      act[k] = 1'b0; bank_of[k] = 1'b0; hang[k] = 1'b0; lo[k] = 3; hi[k] = 3;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        busy_v = '0;
        for (int k = 0; k < 3; k++) begin
          ph[k] = 0; cnt[k] = 0; completed[k] = 0; ngo[k] = 0; act[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (go_v[k]) begin
            ngo[k]++;
            chk($sformatf("go%0d_engine_idle", k), ph[k], 0);
            chk($sformatf("go%0d_bank", k), bank_v[k], completed[k] % 2);
            for (int j = 0; j < 3; j++)
              if (j != k && act[j]) chk("bank_exclusive", bank_v[k] == bank_of[j], 0);
            if (k == 0) chk("load_needs_free_bank", (completed[0] - completed[2]) < 2, 1);
            if (k == 1) chk("fft_needs_loaded", completed[0] > completed[1], 1);
            if (k == 2) chk("unload_needs_done", completed[1] > completed[2], 1);
            if (k == 0 && bp_wait) begin
              chk("bp_load_latency", cyc - bp_drop, 2);
              bp_wait = 1'b0;
            end
            if (!hang[k]) begin
              act[k] = 1'b1;
              bank_of[k] = bank_v[k];
              len[k] = $urandom_range(hi[k], lo[k]);
              cnt[k] = $urandom_range(2, 0);
              if (cnt[k] == 0) begin
                busy_v[k] = 1'b1; ph[k] = 2; cnt[k] = len[k];
              end else begin
                ph[k] = 1;
              end
            end
          end else if (ph[k] == 1) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
              busy_v[k] = 1'b1; ph[k] = 2; cnt[k] = len[k];
            end
          end else if (ph[k] == 2) begin
            chk($sformatf("bank%0d_stable", k), bank_v[k], bank_of[k]);
            cnt[k]--;
            if (cnt[k] == 0) begin
              busy_v[k] = 1'b0; ph[k] = 0; act[k] = 1'b0; completed[k]++;
              if (k == 2 && bp_arm) begin
                bp_drop = cyc; bp_arm = 1'b0; bp_wait = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  task automatic set_lat(input int l0, input int h0, input int l1, input int h1,
                         input int l2, input int h2);
    lo[0] = l0; hi[0] = h0; lo[1] = l1; hi[1] = h1; lo[2] = l2; hi[2] = h2;
  endtask

  task automatic pulse_frame();
    frame_avail = 1'b1;
    @(negedge clk);
    frame_avail = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (completed[2] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frames_within_budget", completed[2] >= n, 1);
    repeat (3) @(negedge clk);
    chk("frame_count", frame_count, n);
    chk("sched_idle_after", sched_idle, 1);
  endtask

  initial begin
    int t;
    int fft_before;
    repeat (3) @(negedge clk);
    chk("rst_load_go", load_go, 0);
    chk("rst_fft_go", fft_go, 0);
    chk("rst_unload_go", unload_go, 0);
    chk("rst_banks", bank_v, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_err", sched_err, 0);
    chk("rst_idle", sched_idle, 1);
    reset_n = 1'b1;
    @(negedge clk);
    sched_en = 1'b1;

    // single frame, fixed engine latencies
    set_lat(10, 10, 40, 40, 20, 20);
    frame_avail = 1'b1;
    @(negedge clk);
    frame_avail = 1'b0;
    chk("load_go_latency", load_go, 1);
    chk("not_idle_while_loading", sched_idle, 0);
    wait_frames(1, 500);

    // streaming, random latencies
    set_lat(3, 30, 3, 30, 3, 30);
    frame_avail = 1'b1;
    t = 0;
    while (ngo[0] < 7 && t < 3000) begin @(negedge clk); t++; end
    frame_avail = 1'b0;
    wait_frames(7, 3000);

    // back-pressure from a slow unloader
    set_lat(5, 5, 10, 10, 500, 500);
    bp_arm = 1'b1;
    frame_avail = 1'b1;
    t = 0;
    while (ngo[0] < 10 && t < 3000) begin @(negedge clk); t++; end
    frame_avail = 1'b0;
    wait_frames(10, 3000);
    chk("bp_latency_measured", bp_wait, 0);

    // FFT busy never rises on first attempt
    set_lat(5, 12, 5, 12, 5, 12);
    hang[1] = 1'b1;
    fft_before = ngo[1];
    pulse_frame();
    t = 0;
    while (!fft_go && t < 200) begin @(negedge clk); t++; end
    chk("fft_go_seen", fft_go, 1);
    repeat (16) @(negedge clk);
    chk("err_before_timeout", sched_err, 0);
    hang[1] = 1'b0;
    @(negedge clk);
    chk("err_at_timeout", sched_err, 1);
    wait_frames(11, 500);
    chk("fft_retried", ngo[1], fft_before + 2);
    chk("err_sticky", sched_err, 1);

    // drain with sched_en low during FFT run
    pulse_frame();
    t = 0;
    while (!busy_v[1] && t < 200) begin @(negedge clk); t++; end
    sched_en = 1'b0;
    t = 0;
    while (completed[1] < 12 && t < 200) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    chk("drain_fft_done", completed[1], 12);
    chk("drain_no_unload", ngo[2], 11);
    chk("drain_not_idle", sched_idle, 0);
    sched_en = 1'b1;
    wait_frames(12, 500);

    // asynchronous reset during unload
    set_lat(5, 5, 5, 5, 50, 50);
    pulse_frame();
    t = 0;
    while (!busy_v[2] && t < 300) begin @(negedge clk); t++; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_gos", go_v, 0);
    chk("arst_banks", bank_v, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_err", sched_err, 0);
    chk("arst_idle", sched_idle, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_frame();
    wait_frames(1, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
